// File: rtl/sm_fv_stream_bank_pkg.sv
// Shared types and sizes for the small feature-value bank: the stream beat
// coming from the big FV bank, the local read request and the fill-FSM states.
package sm_fv_stream_bank_pkg;

  localparam int FV_BW            = 16;
  localparam int FV_MEM_AW        = 10;
  localparam int SM_FV_HALF_DEPTH = 64;
  localparam int SM_FV_AW         = $clog2(SM_FV_HALF_DEPTH);

  localparam logic [SM_FV_AW:0] SM_FV_CNT_MAX = SM_FV_HALF_DEPTH[SM_FV_AW:0];
  localparam logic [SM_FV_AW:0] SM_FV_CNT_ONE = (SM_FV_AW+1)'(1);

  typedef struct packed {
    logic                 sos;
    logic                 eos;
    logic [FV_BW-1:0]     FV_data;
    logic [FV_MEM_AW-1:0] A;
  } FV_MEM2FV_Bank;

  typedef struct packed {
    logic                valid;
    logic [SM_FV_AW-1:0] addr;
    logic                rel;
  } sm_fv_rd_req;

  typedef enum logic [1:0] {
    F_IDLE = 2'd0,
    F_RECV = 2'd1,
    F_DROP = 2'd2
  } sm_fv_fill_e;

  // Beat counter saturates at one full half; longer slices wrap in address only.
  function automatic logic [SM_FV_AW:0] sm_fv_sat_inc(input logic [SM_FV_AW:0] v);
    return (v == SM_FV_CNT_MAX) ? v : v + SM_FV_CNT_ONE;
  endfunction

endpackage

// File: rtl/sm_fv_stream_bank_pp_mem.sv
// Ping-pong line store: 2*HALF_DEPTH lines, one write port and one registered
// read port. Address is {half_sel, line}; the array itself is never reset.
module sm_fv_pp_mem
  import sm_fv_stream_bank_pkg::*;
#(
  parameter int W  = FV_BW,
  parameter int AW = SM_FV_AW
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_we,
  input  logic [AW:0]   i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic          i_re,
  input  logic [AW:0]   i_raddr,
  output logic [W-1:0]  o_rdata
);

  localparam int DEPTH = 2 ** (AW + 1);

  logic [W-1:0] r_mem [DEPTH];
  logic [W-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Read register holds its last value when no read is accepted.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/sm_fv_stream_bank.sv
// Small FV bank: captures streamed replay-iteration slices into a two-half
// buffer so one half fills while the Vertex PE reads the other.
//
// state  | meaning
// F_IDLE | waiting for sos; a sos+eos beat completes a 1-line slice here
// F_RECV | writing beats of a slice into half fill_sel until eos
// F_DROP | no free half at sos; discarding beats until eos
module sm_fv_stream_bank
  import sm_fv_stream_bank_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_reset,
  input  FV_MEM2FV_Bank       i_stream_in,
  input  logic                i_rd_valid,
  input  logic [SM_FV_AW-1:0] i_rd_addr,
  input  logic                i_rd_release,
  output logic                o_rd_data_valid,
  output logic [FV_BW-1:0]    o_rd_data,
  output logic                o_buf_ready,
  output logic [SM_FV_AW:0]   o_line_cnt,
  output logic                o_overflow
);

  localparam int AW = SM_FV_AW;

  sm_fv_fill_e  r_state;
  logic         r_fill_sel;
  logic         r_act_sel;
  logic [1:0]   r_full;
  logic [AW:0]  r_wcnt;
  logic [AW:0]  r_cnt_q [2];
  logic         r_overflow;
  logic         r_rd_data_valid;

  sm_fv_rd_req  w_rd;
  logic         w_sos;
  logic         w_eos;
  logic         w_act_full;
  logic         w_fill_free;
  logic         w_rd_ok;
  logic         w_rel_ok;
  logic         w_we;
  logic         w_fill_done;
  logic [AW:0]  w_wcnt_nxt;
  logic [AW:0]  w_done_cnt;
  logic [1:0]   w_full_set;
  logic [1:0]   w_full_clr;
  logic [AW:0]  w_waddr;
  logic [AW:0]  w_raddr;
  logic         w_unused_a_hi;

  assign w_rd = '{valid: i_rd_valid, addr: i_rd_addr, rel: i_rd_release};

  assign w_sos       = i_stream_in.sos;
  assign w_eos       = i_stream_in.eos;
  assign w_act_full  = r_full[r_act_sel];
  assign w_fill_free = ~r_full[r_fill_sel];

  // Full flags are sampled before this cycle's release takes effect.
  assign w_rd_ok  = w_rd.valid & w_act_full;
  assign w_rel_ok = w_rd.rel & w_act_full;

  assign w_we        = (r_state == F_RECV) | ((r_state == F_IDLE) & w_sos & w_fill_free);
  assign w_fill_done = w_we & w_eos;
  assign w_wcnt_nxt  = sm_fv_sat_inc(r_wcnt);
  assign w_done_cnt  = (r_state == F_RECV) ? w_wcnt_nxt : SM_FV_CNT_ONE;

  // Fill and release never target the same half: fill only writes a non-full half.
  assign w_full_set = w_fill_done ? (2'b01 << r_fill_sel) : 2'b00;
  assign w_full_clr = w_rel_ok    ? (2'b01 << r_act_sel)  : 2'b00;

  // Upper stream address bits are discarded so lines wrap within a half.
  assign w_waddr       = {r_fill_sel, i_stream_in.A[AW-1:0]};
  assign w_unused_a_hi = ^i_stream_in.A[FV_MEM_AW-1:AW];
  assign w_raddr       = {r_act_sel, w_rd.addr};

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state         <= F_IDLE;
      r_fill_sel      <= 1'b0;
      r_act_sel       <= 1'b0;
      r_full          <= 2'b00;
      r_wcnt          <= '0;
      r_cnt_q[0]      <= '0;
      r_cnt_q[1]      <= '0;
      r_overflow      <= 1'b0;
      r_rd_data_valid <= 1'b0;
    end else begin
      r_full          <= (r_full & ~w_full_clr) | w_full_set;
      r_rd_data_valid <= w_rd_ok;

      if (w_rel_ok) begin
        r_act_sel <= ~r_act_sel;
      end

      if (w_fill_done) begin
        r_cnt_q[r_fill_sel] <= w_done_cnt;
        r_fill_sel          <= ~r_fill_sel;
      end

      case (r_state)
        F_IDLE: begin
          if (w_sos) begin
            if (w_fill_free) begin
              r_wcnt <= SM_FV_CNT_ONE;
              if (!w_eos) r_state <= F_RECV;
            end else begin
              r_overflow <= 1'b1;
              if (!w_eos) r_state <= F_DROP;
            end
          end
        end
        F_RECV: begin
          r_wcnt <= w_wcnt_nxt;
          if (w_eos) r_state <= F_IDLE;
        end
        F_DROP: begin
          if (w_eos) r_state <= F_IDLE;
        end
        default: r_state <= F_IDLE;
      endcase
    end
  end

  sm_fv_pp_mem #(
    .W  (FV_BW),
    .AW (AW)
  ) u_mem (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (i_stream_in.FV_data),
    .i_re    (w_rd_ok),
    .i_raddr (w_raddr),
    .o_rdata (o_rd_data)
  );

  assign o_rd_data_valid = r_rd_data_valid;
  assign o_buf_ready     = w_act_full;
  assign o_line_cnt      = w_act_full ? r_cnt_q[r_act_sel] : '0;
  assign o_overflow      = r_overflow;

endmodule

// File: tb/tb_sm_fv_stream_bank.sv
// Scoreboard bench for sm_fv_stream_bank: directed slices followed by random
// stream/read/release traffic, checked against a slice-level reference model.
module tb_sm_fv_stream_bank;
  import sm_fv_stream_bank_pkg::*;

  localparam int HD = SM_FV_HALF_DEPTH;

  logic                clk = 1'b0;
  logic                rst;
  FV_MEM2FV_Bank       sin;
  logic                rv;
  logic [SM_FV_AW-1:0] ra;
  logic                rel;
  logic                o_vld;
  logic [FV_BW-1:0]    o_data;
  logic                o_ready;
  logic [SM_FV_AW:0]   o_cnt;
  logic                o_ovf;

  always #5 clk = ~clk;

  sm_fv_stream_bank dut (
    .i_clk           (clk),
    .i_reset         (rst),
    .i_stream_in     (sin),
    .i_rd_valid      (rv),
    .i_rd_addr       (ra),
    .i_rd_release    (rel),
    .o_rd_data_valid (o_vld),
    .o_rd_data       (o_data),
    .o_buf_ready     (o_ready),
    .o_line_cnt      (o_cnt),
    .o_overflow      (o_ovf)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: slice-level view of the two halves.
  int               m_mode;        // 0 waiting for sos, 1 capturing, 2 discarding
  bit               m_full [2];
  int               m_cnt  [2];
  bit               m_fs, m_as, m_ovf, m_vld;
  int               m_wc;
  logic [FV_BW-1:0] m_mem [2][HD];
  bit               m_wr  [2][HD];
  logic [FV_BW-1:0] m_last;
  logic [FV_BW-1:0] exp_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_close(input int n);
    m_full[m_fs] = 1'b1;
    m_cnt[m_fs]  = n;
    m_fs         = !m_fs;
    m_mode       = 0;
  endtask

  task automatic model_step();
    bit pf [2];
    int a;
    pf[0] = m_full[0];
    pf[1] = m_full[1];
    a = int'(sin.A) % HD;
    if (rst) begin
      m_mode = 0; m_full[0] = 0; m_full[1] = 0; m_cnt[0] = 0; m_cnt[1] = 0;
      m_fs = 0; m_as = 0; m_ovf = 0; m_wc = 0; m_vld = 0; m_last = '0;
      return;
    end
    m_vld = 0;
    if (m_mode == 0) begin
      if (sin.sos) begin
        if (!pf[m_fs]) begin
          m_mem[m_fs][a] = sin.FV_data; m_wr[m_fs][a] = 1;
          m_wc = 1;
          if (sin.eos) model_close(1); else m_mode = 1;
        end else begin
          m_ovf = 1;
          if (!sin.eos) m_mode = 2;
        end
      end
    end else if (m_mode == 1) begin
      m_mem[m_fs][a] = sin.FV_data; m_wr[m_fs][a] = 1;
      m_wc = (m_wc + 1 > HD) ? HD : m_wc + 1;
      if (sin.eos) model_close(m_wc);
    end else begin
      if (sin.eos) m_mode = 0;
    end
    if (rv && pf[m_as]) begin
      m_last = m_mem[m_as][ra];
      m_vld  = 1;
      exp_q.push_back(m_last);
    end
    if (rel && pf[m_as]) begin
      m_full[m_as] = 0;
      m_as = !m_as;
    end
  endtask

  task automatic check_flags();
    chk("buf_ready", 32'(o_ready), 32'(m_full[m_as]));
    chk("line_cnt", 32'(o_cnt), m_full[m_as] ? m_cnt[m_as] : 0);
    chk("overflow", 32'(o_ovf), 32'(m_ovf));
    chk("rd_data_valid", 32'(o_vld), 32'(m_vld));
    chk("rd_data_hold", 32'(o_data), 32'(m_last));
  endtask

  task automatic cyc(input bit r, input bit s, input bit e, input logic [FV_BW-1:0] d,
                     input int a, input bit v, input int addr, input bit rl);
    rst = r; sin.sos = s; sin.eos = e; sin.FV_data = d; sin.A = FV_MEM_AW'(a);
    rv = v; ra = SM_FV_AW'(addr); rel = rl;
    model_step();
    @(posedge clk);
    #1;
    check_flags();
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(0, 0, 0, '0, 0, 0, 0, 0);
  endtask

  task automatic rd(input int addr, input bit rl);
    cyc(0, 0, 0, '0, 0, 1, addr, rl);
  endtask

  task automatic stream(input int n, input int a0, input int d0, input bit rnd,
                        input int rel_at, input int rst_at);
    for (int i = 0; i < n; i++)
      cyc(i == rst_at, i == 0, i == n - 1, rnd ? FV_BW'($urandom) : FV_BW'(d0 + i),
          a0 + i, 0, 0, i == rel_at);
  endtask

  // Monitor: pops an expected word whenever the DUT presents read data.
  always @(negedge clk) begin
    logic [FV_BW-1:0] e;
    if (o_vld === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL rd_data_unexpected: got valid with data %0h, required no read", o_data);
      end else begin
        e = exp_q.pop_front();
        if (o_data !== e) begin
          miscompares++;
          $display("FAIL rd_data: got %0h, required %0h (t=%0t)", o_data, e, $time);
        end
      end
    end
  end

  initial begin
    bit s, e, v, r, l;
    int addr;
    rst = 1; sin = '0; rv = 0; ra = '0; rel = 0;
    for (int h = 0; h < 2; h++)
      for (int i = 0; i < HD; i++) m_wr[h][i] = 0;

    cyc(1, 0, 0, '0, 0, 0, 0, 0);
    cyc(1, 0, 0, '0, 0, 0, 0, 0);
    chk("reset_buf_ready", 32'(o_ready), 0);
    chk("reset_overflow", 32'(o_ovf), 0);
    chk("reset_rd_data", 32'(o_data), 0);

    // 8-beat slice, then reads at both ends
    stream(8, 0, 'h10, 0, -1, -1);
    idle(1);
    chk("s8_line_cnt", 32'(o_cnt), 8);
    rd(0, 0);
    rd(7, 0);
    idle(1);
    chk("s8_rd_last", 32'(o_data), 'h17);

    // Fill both halves, then a third slice must be dropped
    cyc(0, 0, 0, '0, 0, 0, 0, 1);
    stream(HD, 0, 0, 1, -1, -1);
    stream(HD, 0, 0, 1, -1, -1);
    chk("both_full_ovf", 32'(o_ovf), 0);
    stream(10, 3, 'h99, 0, -1, -1);
    chk("drop_ovf", 32'(o_ovf), 1);
    rd(3, 0); rd(12, 0); rd(63, 0);

    // Release while the next slice is still filling
    cyc(0, 0, 0, '0, 0, 0, 0, 1);
    stream(HD, 0, 0, 1, 10, -1);
    idle(1);
    chk("refill_line_cnt", 32'(o_cnt), HD);
    rd(0, 0); rd(40, 0);

    // Single-beat slice
    cyc(0, 0, 0, '0, 0, 0, 0, 1);
    cyc(0, 1, 1, 'hAB, 5, 0, 0, 0);
    chk("one_beat_cnt", 32'(o_cnt), 1);
    rd(5, 1);
    chk("rel_switch_ready", 32'(o_ready), 0);
    rd(5, 0);
    chk("not_ready_valid", 32'(o_vld), 0);
    chk("not_ready_hold", 32'(o_data), 'hAB);

    // Reset on beat 3 of a 10-beat slice, then a fresh slice
    stream(10, 0, 'h30, 0, -1, 2);
    chk("midrst_ready", 32'(o_ready), 0);
    stream(5, 0, 'h50, 0, -1, -1);
    chk("fresh_cnt", 32'(o_cnt), 5);
    for (int i = 0; i < 5; i++) rd(i, 0);

    // Overlong slice saturates the count and wraps the address
    cyc(0, 0, 0, '0, 0, 0, 0, 1);
    stream(HD + 6, 60, 0, 1, -1, -1);
    chk("sat_cnt", 32'(o_cnt), HD);
    rd(60, 0); rd(1, 0);

    // Random traffic
    for (int k = 0; k < 3000; k++) begin
      r    = ($urandom_range(0, 599) == 0);
      s    = ($urandom_range(0, 11) == 0);
      e    = ($urandom_range(0, 24) == 0);
      v    = $urandom_range(0, 1);
      addr = $urandom_range(0, HD - 1);
      l    = ($urandom_range(0, 14) == 0);
      if (m_full[m_as] && !m_wr[m_as][addr]) v = 0;
      cyc(r, s, e, FV_BW'($urandom), $urandom_range(0, 1023), v, addr, l);
    end

    idle(3);
    chk("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sm_fv_stream_bank.md
Name: sm_fv_stream_bank

Overview:
- Downstream consumer of the big feature-value bank's stream to the small FV bank (`FV_MEM2FV_Bank`: sos, eos, FV_data, A).
- Captures each streamed replay-iteration slice into a ping-pong (two-half) local buffer, so the next slice can stream in while the Vertex PE reads the current one.
- Provides a 1-cycle-latency random-read port, a release handshake and an overflow flag.

Parameters:
- FV_BW, `FV_bandwidth, width of one stream beat / buffer line.
- HALF_DEPTH, 64, lines per half (must be a power of 2). Equals lines per replay-iteration slice.
- AW, $clog2(HALF_DEPTH), local line-address width.

Ports:
- clk  in  1  clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- stream_in  in  FV_MEM2FV_Bank  stream beat: sos, eos, FV_data[FV_BW], A.
- rd_valid  in  1  read request.
- rd_addr  in  AW  line address within the active half.
- rd_release  in  1  consumer is finished with the active half.
- rd_data_valid  out  1  registered; asserted the cycle after an accepted read.
- rd_data  out  FV_BW  registered read data.
- buf_ready  out  1  active half is full (a complete slice is readable).
- line_cnt  out  AW+1  number of beats captured into the active half; 0 when not ready.
- overflow  out  1  sticky; a stream arrived with no free half.

Behaviour:
- Reset: all state and flags cleared; fill_sel=0, act_sel=0, full[1:0]=0, overflow=0, rd_data_valid=0, rd_data=0, fill FSM=F_IDLE. Buffer contents are not reset.
- Beat definition: a beat is the cycle with sos in F_IDLE, or any cycle in F_RECV or F_DROP.
  - The beat that carries eos also carries valid data.
  - Cycles in F_IDLE without sos are ignored.
- Write address: A[AW-1:0]. Upper bits of A are discarded, so addresses wrap modulo HALF_DEPTH.
- Fill FSM:
  - F_IDLE + sos, with full[fill_sel]==0: write the beat to half fill_sel, set wcnt=1, go to F_RECV.
  - F_IDLE + sos, with full[fill_sel]==1: drop the beat, set overflow=1, go to F_DROP.
  - sos and eos in the same cycle: a 1-beat slice. Applied immediately: the half is marked full (or dropped), FSM stays in F_IDLE.
  - F_RECV: write each beat and increment wcnt, saturating at HALF_DEPTH. On eos: full[fill_sel]<=1, cnt_q[fill_sel]<=wcnt (including the eos beat), fill_sel<=~fill_sel, go to F_IDLE.
  - F_RECV + sos: treated as an ordinary data beat (no restart).
  - F_DROP: discard beats; on eos go to F_IDLE. fill_sel is unchanged.
- Read side:
  - buf_ready = full[act_sel].
  - line_cnt = buf_ready ? cnt_q[act_sel] : 0.
  - rd_valid with buf_ready: read half act_sel at rd_addr; rd_data/rd_data_valid are registered the next cycle.
  - rd_valid without buf_ready: ignored; rd_data_valid=0 next cycle and rd_data holds its value.
  - rd_release with buf_ready: full[act_sel]<=0, act_sel<=~act_sel.
  - rd_release without buf_ready: ignored.
- Simultaneous events:
  - Read and release in the same cycle: the read is served from the pre-release half.
  - eos filling one half and release of the other half in the same cycle: both take effect.
  - sos arriving in the same cycle that release frees the half at fill_sel: stream is dropped (full is sampled before the update); overflow is set.
- Write/read collision on the same half/line cannot occur: only a non-full half is ever written, and only a full half is ever read.
- Reset mid-stream: the slice is abandoned; remaining beats are ignored until the next sos.

Decomposition:
- Shared package (sys_defs): FV_MEM2FV_Bank typedef (already present), plus new SM_FV_HALF_DEPTH and an sm_fv_rd_req typedef {valid, addr, release}.
- Sub-module sm_fv_pp_mem: a 2*HALF_DEPTH x FV_BW simple dual-port register array.
  - One write port, one synchronous read port.
  - Address = {half_sel, line}.

Test Plan:
- Reset, then one 8-beat stream: sos at A=0, data 0x10..0x17, eos on the 8th beat. Then buf_ready=1, line_cnt=8; reads at addr 0 and 7 return 0x10 and 0x17 one cycle later.
- Two back-to-back 64-beat streams with no release: both halves full, overflow=0. A third sos: beats dropped, overflow=1, half contents unchanged, FSM returns to F_IDLE after eos.
- Release while the second stream is still filling: act_sel switches to half 1. buf_ready goes low until that eos, then high with line_cnt=64.
- Single-cycle sos+eos with A=5, data 0xAB: buf_ready=1, line_cnt=1, read addr 5 returns 0xAB.
- Read and release in the same cycle: rd_data comes from the old half, buf_ready reflects the new half next cycle. A read while not ready gives rd_data_valid=0.
- Reset asserted on beat 3 of a 10-beat stream: all flags clear, later beats ignored. A fresh stream afterwards fills half 0 correctly.
